// File: rtl/bkm_slot_bus_master_pkg.sv
// Shared definitions for the BKM slot bus master: command codes, framing bytes,
// card IDs, FSM state encodings and the captured request record.
package bkm_slot_bus_master_pkg;

    localparam logic [7:0] CMD_IRQ     = 8'h02;
    localparam logic [7:0] CMD_INIT    = 8'h10;
    localparam logic [7:0] CMD_ID      = 8'h20;
    localparam logic [7:0] CMD_VIDEO   = 8'h21;
    localparam logic [7:0] CMD_PREPARE = 8'h22;
    localparam logic [7:0] CMD_SERIAL  = 8'h23;
    localparam logic [7:0] CMD_BLIP0   = 8'h30;
    localparam logic [7:0] CMD_BLIP1   = 8'h40;

    localparam logic [7:0] SEL_BYTE     = 8'hFF;
    localparam logic [7:0] CARD_ID_68X  = 8'h88;
    localparam logic [7:0] CARD_ID_62HS = 8'h82;

    localparam logic [2:0] ST_BUSRST = 3'd0;
    localparam logic [2:0] ST_IDLE   = 3'd1;
    localparam logic [2:0] ST_SEL    = 3'd2;
    localparam logic [2:0] ST_CMD    = 3'd3;
    localparam logic [2:0] ST_ADDR   = 3'd4;
    localparam logic [2:0] ST_DATA   = 3'd5;
    localparam logic [2:0] ST_DESEL  = 3'd6;
    localparam logic [2:0] ST_RESP   = 3'd7;

    typedef struct packed {
        logic [7:0]  cmd;
        logic [15:0] addr;
        logic [1:0]  addr_len;
        logic        read;
        logic [7:0]  wdata;
    } req_t;

    // A length code of 3 means two address bytes on this bus.
    function automatic logic [1:0] clamp_len(input logic [1:0] len);
        return (len == 2'd3) ? 2'd2 : len;
    endfunction

endpackage

// File: rtl/bkm_bus_strobe.sv
// Per-byte strobe timing: LO_CYC cycles of clk_rw low followed by HI_CYC cycles high,
// repeating for as long as run is held.
module bkm_bus_strobe #(
    parameter int LO_CYC = 4,
    parameter int HI_CYC = 4
) (
    input  logic clk_20mhz,
    input  logic reset,
    input  logic run,
    output logic clk_rw,
    output logic first,
    output logic sample,
    output logic done
);
    localparam int CW = $clog2(LO_CYC + HI_CYC);
    localparam logic [CW-1:0] LAST      = CW'(LO_CYC + HI_CYC - 1);
    localparam logic [CW-1:0] SAMPLE_AT = CW'(LO_CYC - 1);
    localparam logic [CW-1:0] HI_START  = CW'(LO_CYC);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    assign cnt_next = (cnt == LAST) ? '0 : cnt + 1'b1;

    // clk_rw is a flop rather than a decode so the card never sees a glitch on it.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk_20mhz) begin
        if (reset || !run) begin
            cnt    <= '0;
            clk_rw <= 1'b0;
        end else begin
            cnt    <= cnt_next;
            clk_rw <= (cnt_next >= HI_START);
        end
    end

    assign first  = run && (cnt == '0);
    assign sample = run && (cnt == SAMPLE_AT);
    assign done   = run && (cnt == LAST);

endmodule

// File: rtl/bkm_slot_bus_master.sv
// Monitor-side BKM slot bus initiator: sequences select, command, address, data and
// deselect bytes for one request, runs the card reset and synchronises int_x.
module bkm_slot_bus_master
    import bkm_slot_bus_master_pkg::*;
#(
    parameter int CLK_LO_CYC  = 4,
    parameter int CLK_HI_CYC  = 4,
    parameter int BUS_RST_CYC = 64
) (
    input  logic        clk_20mhz,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_cmd,
    input  logic [15:0] req_addr,
    input  logic [1:0]  req_addr_len,
    input  logic        req_read,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        slot_x,
    output logic        clk_rw,
    output logic        ax_d,
    output logic        r_wx,
    output logic        bus_reset_x,
    output logic [7:0]  bus_data_out,
    output logic        bus_data_oe,
    input  logic [7:0]  bus_data_in,
    input  logic        int_x,
    output logic        irq
);
    localparam int RCW = $clog2(BUS_RST_CYC + 1);
    localparam logic [RCW-1:0] RST_LAST = RCW'(BUS_RST_CYC - 1);

    logic [2:0]     state;
    logic [RCW-1:0] rst_cnt;
    logic           addr_idx;
    req_t           req_q;
    logic           in_bus;
    logic           byte_first;
    logic           byte_sample;
    logic           byte_done;
    logic           int_meta;
    logic           int_sync;

    assign in_bus = (state == ST_SEL) || (state == ST_CMD) || (state == ST_ADDR) ||
                    (state == ST_DATA) || (state == ST_DESEL);

    bkm_bus_strobe #(
        .LO_CYC (CLK_LO_CYC),
        .HI_CYC (CLK_HI_CYC)
    ) u_strobe (
        .clk_20mhz (clk_20mhz),
        .reset     (reset),
        .run       (in_bus),
        .clk_rw    (clk_rw),
        .first     (byte_first),
        .sample    (byte_sample),
        .done      (byte_done)
    );

    always_ff @(posedge clk_20mhz) begin
        if (reset) begin
            state    <= ST_BUSRST;
            rst_cnt  <= '0;
            addr_idx <= 1'b0;
        end else begin
            case (state)
                ST_BUSRST: begin
                    if (rst_cnt == RST_LAST) state <= ST_IDLE;
                    else                     rst_cnt <= rst_cnt + 1'b1;
                end
                ST_IDLE: begin
                    addr_idx <= 1'b0;
                    if (req_valid) state <= ST_SEL;
                end
                ST_SEL:   if (byte_done) state <= ST_CMD;
                ST_CMD:   if (byte_done) state <= (req_q.addr_len == 2'd0) ? ST_DATA : ST_ADDR;
                ST_ADDR: begin
                    if (byte_done) begin
                        if (addr_idx || req_q.addr_len == 2'd1) state <= ST_DATA;
                        else                                    addr_idx <= 1'b1;
                    end
                end
                ST_DATA:  if (byte_done) state <= ST_DESEL;
                ST_DESEL: if (byte_done) state <= ST_RESP;
                ST_RESP:  state <= ST_IDLE;
                default:  state <= ST_BUSRST;
            endcase
        end
    end

    // NOTE: the request record is pure datapath, only read in states that follow a
    // capture, so it carries no reset.
    always_ff @(posedge clk_20mhz) begin
        if (state == ST_IDLE && req_valid) begin
            req_q <= '{cmd:      req_cmd,
                       addr:     req_addr,
                       addr_len: clamp_len(req_addr_len),
                       read:     req_read,
                       wdata:    req_wdata};
        end
    end

    always_ff @(posedge clk_20mhz) begin
        if (reset) begin
            rsp_rdata <= 8'h00;
            int_meta  <= 1'b1;
            int_sync  <= 1'b1;
        end else begin
            if (state == ST_DATA && req_q.read && byte_sample) rsp_rdata <= bus_data_in;
            int_meta <= int_x;
            int_sync <= int_meta;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        ax_d         = 1'b0;
        r_wx         = 1'b1;
        bus_data_out = SEL_BYTE;
        bus_data_oe  = (state != ST_BUSRST);
        case (state)
            ST_SEL: r_wx = 1'b0;
            ST_CMD: begin
                r_wx         = 1'b0;
                bus_data_out = req_q.cmd;
            end
            ST_ADDR: begin
                r_wx         = 1'b0;
                bus_data_out = addr_idx ? req_q.addr[15:8] : req_q.addr[7:0];
            end
            ST_DATA: begin
                ax_d = 1'b1;
                r_wx = req_q.read;
                if (req_q.read) bus_data_oe  = 1'b0;
                else            bus_data_out = req_q.wdata;
            end
            ST_DESEL: begin
                r_wx = 1'b0;
                // One cycle of bus turnaround so the card releases before we drive.
                if (req_q.read && byte_first) bus_data_oe = 1'b0;
            end
            default: ;
        endcase
    end

    assign req_ready   = (state == ST_IDLE);
    assign rsp_valid   = (state == ST_RESP);
    assign slot_x      = !in_bus;
    assign bus_reset_x = (state != ST_BUSRST);
    assign irq         = !int_sync;

endmodule
